// File: rtl/nios2_oci_trace_arbiter_if.sv
// Signal bundle joining DCT capture, the host read path and the trace RAM port to the arbiter.
// The arbiter takes the slave view; the surrounding logic (or a bench) takes the master view.
interface nios2_oci_trace_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 34
);
  logic          dct_valid;
  logic          dct_ready;
  logic [29:0]   dct_buffer;
  logic [3:0]    dct_count;
  logic          host_rd_req;
  logic [AW-1:0] host_rd_addr;
  logic          host_rd_ack;
  logic [DW-1:0] host_rd_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] wr_ptr;
  logic          wrapped;
  logic          test_ending;
  logic          test_has_ended;

  modport slave (
    input  dct_valid, dct_buffer, dct_count,
    input  host_rd_req, host_rd_addr,
    input  ram_rdata,
    input  test_ending,
    output dct_ready,
    output host_rd_ack, host_rd_data,
    output ram_addr, ram_we, ram_wdata,
    output wr_ptr, wrapped, test_has_ended
  );

  modport master (
    output dct_valid, dct_buffer, dct_count,
    output host_rd_req, host_rd_addr,
    output ram_rdata,
    output test_ending,
    input  dct_ready,
    input  host_rd_ack, host_rd_data,
    input  ram_addr, ram_we, ram_wdata,
    input  wr_ptr, wrapped, test_has_ended
  );
endinterface

// File: rtl/nios2_oci_trace_arbiter.sv
// Sequences DCT frames into a single-port trace RAM and shares the port with host reads;
// handles the end-of-test flush (stop capture, drain the held frame, raise test_has_ended).
module nios2_oci_trace_arbiter #(
  parameter int AW = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  nios2_oci_trace_arbiter_if.slave  bus
);
  localparam int DW = 34;

  typedef enum logic [1:0] {ST_RUN, ST_RD_WAIT, ST_ENDED} state_t;
  typedef enum logic {GR_READ, GR_WRITE} grant_t;

  state_t        r_state;
  state_t        w_state_nxt;
  grant_t        r_last_grant;
  grant_t        w_last_grant_nxt;

  logic          r_hold_valid;
  logic [DW-1:0] r_hold;
  logic          r_end_req;
  logic [AW-1:0] r_wr_ptr;
  logic          r_wrapped;
  logic          r_test_has_ended;

  logic          w_dct_ready;
  logic          w_accept;
  logic          w_wr_cand;
  logic          w_wr_grant;
  logic          w_rd_grant;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;
  logic          w_host_rd_ack;
  logic [DW-1:0] w_host_rd_data;

  assign w_accept  = bus.dct_valid && w_dct_ready;
  assign w_wr_cand = r_hold_valid && (r_state == ST_RUN);

  // Arbitration and next state; while reset is high every output is forced
  // idle so an abandoned read never produces an ack.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_dct_ready      = 1'b0;
    w_wr_grant       = 1'b0;
    w_rd_grant       = 1'b0;
    w_ram_we         = 1'b0;
    w_ram_addr       = '0;
    w_ram_wdata      = '0;
    w_host_rd_ack    = 1'b0;
    w_host_rd_data   = '0;

    if (!reset) begin
      w_dct_ready = !r_hold_valid && !r_end_req && (r_state != ST_ENDED);

      case (r_state)
        ST_RUN, ST_ENDED: begin
          if (w_wr_cand && bus.host_rd_req) begin
            if (r_last_grant == GR_READ) w_wr_grant = 1'b1;
            else                         w_rd_grant = 1'b1;
          end else if (w_wr_cand) begin
            w_wr_grant = 1'b1;
          end else if (bus.host_rd_req) begin
            w_rd_grant = 1'b1;
          end

          if (w_wr_grant) begin
            w_ram_we         = 1'b1;
            w_ram_addr       = r_wr_ptr;
            w_ram_wdata      = r_hold;
            w_last_grant_nxt = GR_WRITE;
          end else if (w_rd_grant) begin
            w_ram_addr       = bus.host_rd_addr;
            w_last_grant_nxt = GR_READ;
            w_state_nxt      = ST_RD_WAIT;
          end else if (r_end_req && !r_hold_valid) begin
            w_state_nxt = ST_ENDED;
          end
        end

        ST_RD_WAIT: begin
          w_host_rd_ack  = 1'b1;
          w_host_rd_data = bus.ram_rdata;
          w_state_nxt    = (r_end_req && !r_hold_valid) ? ST_ENDED : ST_RUN;
        end

        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_RUN;
      r_last_grant     <= GR_READ;
      r_hold_valid     <= 1'b0;
      r_end_req        <= 1'b0;
      r_wr_ptr         <= '0;
      r_wrapped        <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;

      if (bus.test_ending) r_end_req <= 1'b1;

      // Empty frames are consumed by the handshake but never occupy the hold slot.
      if (w_wr_grant)                             r_hold_valid <= 1'b0;
      else if (w_accept && bus.dct_count != 4'd0) r_hold_valid <= 1'b1;

      if (w_wr_grant) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (&r_wr_ptr) r_wrapped <= 1'b1;
      end

      if (w_state_nxt == ST_ENDED) r_test_has_ended <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && bus.dct_count != 4'd0) r_hold <= {bus.dct_count, bus.dct_buffer};
  end

  assign bus.dct_ready      = w_dct_ready;
  assign bus.host_rd_ack    = w_host_rd_ack;
  assign bus.host_rd_data   = w_host_rd_data;
  assign bus.ram_addr       = w_ram_addr;
  assign bus.ram_we         = w_ram_we;
  assign bus.ram_wdata      = w_ram_wdata;
  assign bus.wr_ptr         = r_wr_ptr;
  assign bus.wrapped        = r_wrapped;
  assign bus.test_has_ended = r_test_has_ended;

endmodule

// File: tb/tb_nios2_oci_trace_arbiter.sv
// Directed bench for the trace arbiter: a RAM model behind the port, expected writes and
// host read data queued when stimulus is issued and checked when the DUT produces them.
module tb_nios2_oci_trace_arbiter;
  localparam int AW = 3;
  localparam int DW = 34;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  nios2_oci_trace_arbiter_if #(.AW(AW), .DW(DW)) bus();

  nios2_oci_trace_arbiter #(.AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0]    ram_mem [0:(1<<AW)-1];
  logic [DW-1:0]    ram_rd_q;
  logic [DW-1:0]    exp_mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW-1:0]    exp_rd_q[$];
  logic [AW-1:0]    exp_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model with one cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    ram_rd_q <= ram_mem[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ram_we) begin
      if (exp_wr_q.size() == 0) chk("unexpected_write", {bus.ram_addr, bus.ram_wdata}, '0);
      else chk("ram_write", {bus.ram_addr, bus.ram_wdata}, exp_wr_q.pop_front());
    end
    if (bus.host_rd_ack) begin
      if (exp_rd_q.size() == 0) chk("unexpected_ack", bus.host_rd_data, '0);
      else chk("host_rd_data", bus.host_rd_data, exp_rd_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_ptr = '0;
  endtask

  task automatic expect_write(input logic [3:0] c, input logic [29:0] p);
    exp_wr_q.push_back({exp_ptr, c, p});
    exp_mem[exp_ptr] = {c, p};
    exp_ptr = exp_ptr + 1'b1;
  endtask

  // Offer one frame; returns in the cycle after the accepting edge.
  task automatic offer(input logic [3:0] c, input logic [29:0] p);
    int n = 0;
    bus.dct_valid  = 1'b1;
    bus.dct_count  = c;
    bus.dct_buffer = p;
    #1;
    while (!bus.dct_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("offer_ready", bus.dct_ready, 1'b1);
    if (c != 4'd0) expect_write(c, p);
    tick();
    bus.dct_valid = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a);
    int n = 0;
    exp_rd_q.push_back(exp_mem[a]);
    bus.host_rd_req  = 1'b1;
    bus.host_rd_addr = a;
    #1;
    while (!bus.host_rd_ack && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("host_ack_seen", bus.host_rd_ack, 1'b1);
    tick();
    bus.host_rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.dct_valid    = 1'b0;
    bus.dct_buffer   = '0;
    bus.dct_count    = '0;
    bus.host_rd_req  = 1'b0;
    bus.host_rd_addr = '0;
    bus.test_ending  = 1'b0;
    exp_ptr          = '0;

    // Reset state: every output low while reset is held.
    tick();
    tick();
    #1;
    chk("rst_dct_ready", bus.dct_ready, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ack", bus.host_rd_ack, 1'b0);
    chk("rst_wr_ptr", bus.wr_ptr, '0);
    chk("rst_wrapped", bus.wrapped, 1'b0);
    chk("rst_ended", bus.test_has_ended, 1'b0);
    reset = 1'b0;
    tick();
    #1;
    chk("post_rst_ready", bus.dct_ready, 1'b1);

    // Three count=5 frames land at addresses 0..2.
    offer(4'd5, 30'h0AAA_AAAA);
    offer(4'd5, 30'h0BBB_BBBB);
    offer(4'd5, 30'h0CCC_CCCC);
    tick();
    chk("wr_ptr_after3", bus.wr_ptr, 3);
    host_read(3'd1);

    // An empty frame is accepted but never written.
    offer(4'd5, 30'h0DDD_DDDD);
    offer(4'd0, 30'h0EEE_EEEE);
    offer(4'd5, 30'h0FFF_FFFF);
    tick();
    chk("wr_ptr_skip_empty", bus.wr_ptr, 5);
    host_read(3'd4);

    // Nine frames into an 8-deep RAM: wrap after the 8th.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      offer(4'(i + 1), 30'(32'h100 + i));
      tick();
      chk("wrap_flag", bus.wrapped, (i >= 7) ? 1'b1 : 1'b0);
    end
    chk("wr_ptr_after_wrap", bus.wr_ptr, 1);
    host_read(3'd0);
    host_read(3'd7);

    // Write and read contend with last_grant=READ after reset: write wins.
    do_reset();
    bus.dct_valid  = 1'b1;
    bus.dct_count  = 4'd7;
    bus.dct_buffer = 30'h1234_5678;
    #1;
    chk("c_ready", bus.dct_ready, 1'b1);
    tick();
    bus.dct_valid = 1'b0;
    expect_write(4'd7, 30'h1234_5678);
    exp_rd_q.push_back(exp_mem[0]);
    bus.host_rd_req  = 1'b1;
    bus.host_rd_addr = 3'd0;
    #1;
    chk("c_write_first", {bus.ram_we, bus.ram_addr}, {1'b1, 3'd0});
    tick();
    #1;
    chk("c_read_second", {bus.ram_we, bus.ram_addr, bus.host_rd_ack}, {1'b0, 3'd0, 1'b0});
    tick();
    #1;
    chk("c_ack_lat", bus.host_rd_ack, 1'b1);
    tick();
    bus.host_rd_req = 1'b0;

    // End of test with a frame held: frame drains, then test_has_ended.
    bus.dct_valid  = 1'b1;
    bus.dct_count  = 4'd3;
    bus.dct_buffer = 30'h2AB_CDEF;
    #1;
    tick();
    bus.dct_valid = 1'b0;
    expect_write(4'd3, 30'h2AB_CDEF);
    bus.test_ending = 1'b1;
    #1;
    chk("e_write_held", {bus.ram_we, bus.ram_addr}, {1'b1, 3'd1});
    tick();
    bus.test_ending = 1'b0;
    #1;
    chk("e_ready_dropped", bus.dct_ready, 1'b0);
    begin
      int n = 0;
      while (!bus.test_has_ended && n < 5) begin
        tick();
        #1;
        n++;
      end
    end
    chk("e_has_ended", bus.test_has_ended, 1'b1);
    bus.dct_valid  = 1'b1;
    bus.dct_count  = 4'd9;
    bus.dct_buffer = 30'h3FF_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("e_ready_low", bus.dct_ready, 1'b0);
    end
    bus.dct_valid = 1'b0;
    host_read(3'd1);
    chk("e_wr_ptr", bus.wr_ptr, 2);

    // Reset during RD_WAIT: the read is abandoned without an ack.
    bus.host_rd_req  = 1'b1;
    bus.host_rd_addr = 3'd2;
    #1;
    chk("r_read_grant", {bus.ram_we, bus.ram_addr}, {1'b0, 3'd2});
    tick();
    reset = 1'b1;
    bus.host_rd_req = 1'b0;
    #1;
    chk("r_no_ack", bus.host_rd_ack, 1'b0);
    tick();
    #1;
    chk("r_outputs_zero",
        {bus.dct_ready, bus.host_rd_ack, bus.host_rd_data, bus.ram_addr, bus.ram_we,
         bus.ram_wdata, bus.wr_ptr, bus.wrapped, bus.test_has_ended}, '0);
    reset = 1'b0;
    exp_ptr = '0;
    tick();
    #1;
    chk("r_ready_again", bus.dct_ready, 1'b1);
    host_read(3'd1);

    tick();
    tick();
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
